// File: rtl/pb_event_debounce.sv
// Push-button conditioner: synchroniser, stable-count debounce and
// per-channel press/release/long-press/auto-repeat event generation.
module pb_event_debounce #(
  parameter int NUM_BTN      = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_CYC     = 1000,
  parameter int REPEAT_CYC   = 250,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pb_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] released,
  output logic [NUM_BTN-1:0] long_press,
  output logic [NUM_BTN-1:0] repeat_evt
);

  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYC < 1) begin : g_err_deb
    $error("DEBOUNCE_CYC must be >= 1");
  end
  if (LONG_CYC < 1) begin : g_err_long
    $error("LONG_CYC must be >= 1");
  end

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam int RW = (REPEAT_CYC > 0) ? $clog2(REPEAT_CYC + 1) : 1;
  localparam int REP_M1 = (REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0;

  localparam logic          IDLE_LVL = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP_M1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_LONG
  } st_e;

  logic [SYNC_STAGES-1:0] sync_q [NUM_BTN];
  logic [SYNC_STAGES-1:0] sync_d [NUM_BTN];
  logic [DW-1:0]          deb_q  [NUM_BTN];
  logic [DW-1:0]          deb_d  [NUM_BTN];
  logic [HW-1:0]          hold_q [NUM_BTN];
  logic [HW-1:0]          hold_d [NUM_BTN];
  logic [RW-1:0]          rep_q  [NUM_BTN];
  logic [RW-1:0]          rep_d  [NUM_BTN];
  st_e                    st_q   [NUM_BTN];
  st_e                    st_d   [NUM_BTN];

  logic [NUM_BTN-1:0] sync_in;
  logic [NUM_BTN-1:0] lvl_q, lvl_d;
  logic [NUM_BTN-1:0] prs_q, prs_d;
  logic [NUM_BTN-1:0] rls_q, rls_d;
  logic [NUM_BTN-1:0] lp_q, lp_d;
  logic [NUM_BTN-1:0] rp_q, rp_d;

  always_comb begin
    sync_in = '0;
    lvl_d   = lvl_q;
    prs_d   = '0;
    rls_d   = '0;
    lp_d    = '0;
    rp_d    = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pb_in[i]};
      deb_d[i]  = '0;
      hold_d[i] = hold_q[i];
      rep_d[i]  = rep_q[i];
      st_d[i]   = st_q[i];
      sync_in[i] = sync_q[i][SYNC_STAGES-1] ^ IDLE_LVL;

      if (sync_in[i] != lvl_q[i]) begin
        if (deb_q[i] == DEB_LAST) begin
          lvl_d[i] = sync_in[i];
          prs_d[i] = sync_in[i];
          rls_d[i] = ~sync_in[i];
        end else begin
          deb_d[i] = deb_q[i] + DW'(1);
        end
      end

      // An accepted release wins over any long/repeat event due this edge
      unique case (st_q[i])
        S_IDLE: begin
          if (prs_d[i]) begin
            st_d[i]   = S_HOLD;
            hold_d[i] = '0;
          end
        end
        S_HOLD: begin
          if (rls_d[i]) begin
            st_d[i]   = S_IDLE;
            hold_d[i] = '0;
          end else begin
            hold_d[i] = hold_q[i] + HW'(1);
            if (hold_q[i] == HOLD_LAST) begin
              st_d[i]  = S_LONG;
              lp_d[i]  = 1'b1;
              rep_d[i] = '0;
            end
          end
        end
        S_LONG: begin
          if (rls_d[i]) begin
            st_d[i]   = S_IDLE;
            hold_d[i] = '0;
            rep_d[i]  = '0;
          end else if (REPEAT_CYC > 0) begin
            if (rep_q[i] == REP_LAST) begin
              rep_d[i] = '0;
              rp_d[i]  = 1'b1;
            end else begin
              rep_d[i] = rep_q[i] + RW'(1);
            end
          end
        end
        default: begin
          st_d[i]   = S_IDLE;
          hold_d[i] = '0;
          rep_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        sync_q[i] <= {SYNC_STAGES{IDLE_LVL}};
        deb_q[i]  <= '0;
        hold_q[i] <= '0;
        rep_q[i]  <= '0;
        st_q[i]   <= S_IDLE;
      end
      lvl_q <= '0;
      prs_q <= '0;
      rls_q <= '0;
      lp_q  <= '0;
      rp_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        sync_q[i] <= sync_d[i];
        deb_q[i]  <= deb_d[i];
        hold_q[i] <= hold_d[i];
        rep_q[i]  <= rep_d[i];
        st_q[i]   <= st_d[i];
      end
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      rls_q <= rls_d;
      lp_q  <= lp_d;
      rp_q  <= rp_d;
    end
  end

  assign btn_level  = lvl_q;
  assign pressed    = prs_q;
  assign released   = rls_q;
  assign long_press = lp_q;
  assign repeat_evt = rp_q;

endmodule

// File: tb/tb_pb_event_debounce.sv
// Directed bench for pb_event_debounce: two channels, debounce 4,
// long-press 10, repeat 3, active-low buttons.
module tb_pb_event_debounce;

  logic       clk;
  logic       rst;
  logic [1:0] pb_in;
  logic [1:0] btn_level;
  logic [1:0] pressed;
  logic [1:0] released;
  logic [1:0] long_press;
  logic [1:0] repeat_evt;

  int checks;
  int errors;

  logic [9:0] obs;
  logic [9:0] exp_v;

  pb_event_debounce #(
    .NUM_BTN     (2),
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (10),
    .REPEAT_CYC  (3),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_in     (pb_in),
    .btn_level (btn_level),
    .pressed   (pressed),
    .released  (released),
    .long_press(long_press),
    .repeat_evt(repeat_evt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign obs = {btn_level, pressed, released, long_press, repeat_evt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    pb_in = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (obs !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold k=%0d got %b exp %b", k, obs, 10'd0);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (obs !== 10'd0) begin
        errors++;
        $display("FAIL reset_release k=%0d got %b exp %b", k, obs, 10'd0);
      end
    end
  endtask

  task automatic test_clean_press();
    pb_in[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_v = {1'b0, k >= 6, 1'b0, k == 6, 6'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_press k=%0d got %b exp %b", k, obs, exp_v);
      end
    end
  endtask

  // Debounced level stays pressed 8 cycles: release raw at P+2
  task automatic test_short_press();
    tick();
    pb_in[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_v = {1'b0, k < 6, 2'b00, 1'b0, k == 6, 4'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL short_press k=%0d got %b exp %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 3; r++) begin
      pb_in[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++;
        if (obs !== 10'd0) begin
          errors++;
          $display("FAIL bounce_low r=%0d k=%0d got %b", r, k, obs);
        end
      end
      pb_in[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++;
        if (obs !== 10'd0) begin
          errors++;
          $display("FAIL bounce_high r=%0d k=%0d got %b", r, k, obs);
        end
      end
    end
    pb_in[0] = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_v = {1'b0, (k >= 6 && k < 12), 1'b0, k == 6,
               1'b0, k == 12, 4'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_settle k=%0d got %b exp %b", k, obs, exp_v);
      end
      if (k == 6) pb_in[0] = 1'b1;
    end
  endtask

  // Release lands on the edge a repeat is due (k=34): repeat suppressed
  task automatic test_long_repeat();
    pb_in[1] = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      tick();
      exp_v = {(k >= 6 && k < 34), 1'b0,
               k == 6, 1'b0,
               k == 34, 1'b0,
               k == 16, 1'b0,
               (k == 19 || k == 22 || k == 25 || k == 28 || k == 31),
               1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long_repeat k=%0d got %b exp %b", k, obs, exp_v);
      end
      if (k == 28) pb_in[1] = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    pb_in = 2'b00;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_v = {(k >= 6 && k < 14), (k >= 6 && k < 12),
               (k == 6) ? 2'b11 : 2'b00,
               k == 14, k == 12,
               4'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simultaneous k=%0d got %b exp %b", k, obs, exp_v);
      end
      if (k == 6) pb_in[0] = 1'b1;
      if (k == 8) pb_in[1] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_hold();
    pb_in = 2'b01;
    for (int k = 1; k <= 18; k++) tick();
    checks++;
    if (btn_level !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_level got %b exp %b", btn_level, 2'b10);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 10'd0) begin
      errors++;
      $display("FAIL reset_async got %b exp %b", obs, 10'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_v = {k >= 6, 1'b0, k == 6, 1'b0, 2'b00,
               k == 16, 1'b0, 2'b00};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid k=%0d got %b exp %b", k, obs, exp_v);
      end
    end
    pb_in = 2'b11;
    for (int k = 1; k <= 8; k++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    pb_in  = 2'b11;
    test_reset();
    test_clean_press();
    test_short_press();
    test_bounce();
    test_long_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
